// File: rtl/sq_fetch_scheduler.sv
// sq_fetch_scheduler
// Walks the RDMA send queue from the hardware head toward the software tail.
// For each pending WQE it issues one 72-bit DataMover MM2S read command.
// It then waits for the read to finish and advances the head, wrapping at sq_size.
//
// Optional build macro: STS_CHECK_EN
//   Defined   : WAIT also needs an OKAY status beat carrying the issued tag.
//               A bad status sets err_flag and parks the FSM in ERR.
//   Undefined : the status channel is drained and ignored.
//               The completion pulse alone finishes a fetch.
module sq_fetch_scheduler #(
    parameter int IDX_W     = 4,
    parameter int WQE_BYTES = 64,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              global_enable,
    input  logic              sq_head_clr,
    input  logic [ADDR_W-1:0] sq_base_addr,
    input  logic [IDX_W-1:0]  sq_size,
    input  logic [IDX_W-1:0]  sq_tail,
    output logic [IDX_W-1:0]  hw_sq_head,
    output logic              mm2s_cmd_tvalid,
    input  logic              mm2s_cmd_tready,
    output logic [71:0]       mm2s_cmd_tdata,
    input  logic              mm2s_rd_xfer_cmplt,
    input  logic              mm2s_sts_tvalid,
    output logic              mm2s_sts_tready,
    input  logic [7:0]        mm2s_sts_tdata,
    output logic              busy,
    output logic              err_flag,
    output logic [31:0]       wqe_processed,
    output logic [31:0]       status_word
);

    localparam int SHIFT = $clog2(WQE_BYTES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        WAIT = 2'd2,
        ERR  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  head_q, head_d;
    logic [IDX_W-1:0]  size_q, size_d;
    logic              err_q, err_d;
    logic [31:0]       cnt_q, cnt_d;
    logic [71:0]       cmd_q, cmd_d;

    logic              fetchReq;
    logic              badIdx;
    logic              startOk;
    logic              startBad;
    logic              clrHead;
    logic              cmdFire;
    logic              fetchDone;
    logic              stsErr;
    logic [IDX_W-1:0]  headInc;
    logic [ADDR_W-1:0] headOff;
    logic [ADDR_W-1:0] saddr;
    logic [71:0]       newCmd;

    assign fetchReq = global_enable && !err_q && (sq_size != '0) && (head_q != sq_tail);
    assign badIdx   = (sq_tail >= sq_size) || (head_q >= sq_size);
    assign clrHead  = (state_q == IDLE) && sq_head_clr;
    assign startOk  = (state_q == IDLE) && !sq_head_clr && fetchReq && !badIdx;
    assign startBad = (state_q == IDLE) && !sq_head_clr && fetchReq && badIdx;
    assign cmdFire  = (state_q == CMD) && mm2s_cmd_tready;
    assign headInc  = head_q + 1'b1;
    assign headOff  = ADDR_W'(head_q) << SHIFT;
    assign saddr    = sq_base_addr + headOff;
    assign newCmd   = {4'h0, 4'(head_q), 32'(saddr), 1'b0, 1'b1, 6'h00, 1'b1, 23'(WQE_BYTES)};

`ifdef STS_CHECK_EN
    logic cmpltSeen_q, cmpltSeen_d;
    logic stsSeen_q, stsSeen_d;
    logic stsFire;
    logic stsBad;

    assign stsFire   = (state_q == WAIT) && mm2s_sts_tvalid;
    assign stsBad    = stsFire && (!mm2s_sts_tdata[7] || (mm2s_sts_tdata[6:4] != 3'b000)
                                   || (mm2s_sts_tdata[3:0] != cmd_q[67:64]));
    assign stsErr    = stsBad;
    assign fetchDone = (state_q == WAIT) && !stsBad
                       && (cmpltSeen_q || mm2s_rd_xfer_cmplt)
                       && (stsSeen_q || stsFire);

    // Remember which of completion / status has already arrived during WAIT
    always_comb begin
        cmpltSeen_d = 1'b0;
        stsSeen_d   = 1'b0;
        if ((state_q == WAIT) && !fetchDone && !stsErr) begin
            cmpltSeen_d = cmpltSeen_q || mm2s_rd_xfer_cmplt;
            stsSeen_d   = stsSeen_q || stsFire;
        end
    end

    // Completion/status tracking flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmpltSeen_q <= 1'b0;
            stsSeen_q   <= 1'b0;
        end else begin
            cmpltSeen_q <= cmpltSeen_d;
            stsSeen_q   <= stsSeen_d;
        end
    end
`else
    logic sts_unused;

    assign sts_unused = ^{mm2s_sts_tvalid, mm2s_sts_tdata};
    assign stsErr     = 1'b0;
    assign fetchDone  = (state_q == WAIT) && mm2s_rd_xfer_cmplt;
`endif

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (startBad) begin
                    state_d = ERR;
                end else if (startOk) begin
                    state_d = CMD;
                end
            end
            CMD: begin
                if (cmdFire) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (stsErr) begin
                    state_d = ERR;
                end else if (fetchDone) begin
                    state_d = IDLE;
                end
            end
            ERR: begin
                if (!global_enable) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: head, sampled size, error flag, counter, command word
    always_comb begin
        head_d = head_q;
        size_d = size_q;
        err_d  = err_q;
        cnt_d  = cnt_q;
        cmd_d  = cmd_q;
        if (clrHead) begin
            head_d = '0;
            err_d  = 1'b0;
        end
        if (startBad || stsErr) begin
            err_d = 1'b1;
        end
        if (startOk) begin
            cmd_d  = newCmd;
            size_d = sq_size;
        end
        if (fetchDone) begin
            head_d = (headInc == size_q) ? '0 : headInc;
            cnt_d  = cnt_q + 32'd1;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            size_q <= '0;
            err_q  <= 1'b0;
            cnt_q  <= '0;
            cmd_q  <= '0;
        end else begin
            head_q <= head_d;
            size_q <= size_d;
            err_q  <= err_d;
            cnt_q  <= cnt_d;
            cmd_q  <= cmd_d;
        end
    end

    // FSM-driven outputs and register readback
    always_comb begin
        mm2s_cmd_tvalid = (state_q == CMD);
        busy            = (state_q != IDLE);
`ifdef STS_CHECK_EN
        mm2s_sts_tready = (state_q == WAIT);
`else
        mm2s_sts_tready = 1'b1;
`endif
        mm2s_cmd_tdata  = cmd_q;
        hw_sq_head      = head_q;
        err_flag        = err_q;
        wqe_processed   = cnt_q;
        status_word     = {16'h0000, state_q, 2'b00, err_q, (state_q != IDLE), 2'b00,
                           4'(sq_tail), 4'(head_q)};
    end

endmodule

// File: tb/tb_sq_fetch_scheduler.sv
// tb_sq_fetch_scheduler
// Directed bench for sq_fetch_scheduler.
// Each command the stimulus expects is pushed into a scoreboard queue.
// A monitor pops and compares the queue on every command handshake.
// Build with STS_CHECK_EN defined to also exercise the status-checking path.
module tb_sq_fetch_scheduler;

    logic        clk;
    logic        rst_n;
    logic        global_enable;
    logic        sq_head_clr;
    logic [31:0] sq_base_addr;
    logic [3:0]  sq_size;
    logic [3:0]  sq_tail;
    logic [3:0]  hw_sq_head;
    logic        mm2s_cmd_tvalid;
    logic        mm2s_cmd_tready;
    logic [71:0] mm2s_cmd_tdata;
    logic        mm2s_rd_xfer_cmplt;
    logic        mm2s_sts_tvalid;
    logic        mm2s_sts_tready;
    logic [7:0]  mm2s_sts_tdata;
    logic        busy;
    logic        err_flag;
    logic [31:0] wqe_processed;
    logic [31:0] status_word;

    int checks = 0;
    int errors = 0;
    logic [71:0] sb[$];

    sq_fetch_scheduler #(.IDX_W(4), .WQE_BYTES(64), .ADDR_W(32)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .global_enable      (global_enable),
        .sq_head_clr        (sq_head_clr),
        .sq_base_addr       (sq_base_addr),
        .sq_size            (sq_size),
        .sq_tail            (sq_tail),
        .hw_sq_head         (hw_sq_head),
        .mm2s_cmd_tvalid    (mm2s_cmd_tvalid),
        .mm2s_cmd_tready    (mm2s_cmd_tready),
        .mm2s_cmd_tdata     (mm2s_cmd_tdata),
        .mm2s_rd_xfer_cmplt (mm2s_rd_xfer_cmplt),
        .mm2s_sts_tvalid    (mm2s_sts_tvalid),
        .mm2s_sts_tready    (mm2s_sts_tready),
        .mm2s_sts_tdata     (mm2s_sts_tdata),
        .busy               (busy),
        .err_flag           (err_flag),
        .wqe_processed      (wqe_processed),
        .status_word        (status_word)
    );

    // 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected command word: BTT=64, INCR, EOF, given SADDR and tag
    function automatic logic [71:0] mkCmd(input logic [31:0] saddr, input logic [3:0] tag);
        return {4'h0, tag, saddr, 1'b0, 1'b1, 6'h00, 1'b1, 23'd64};
    endfunction

    task automatic checkOutput(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic [31:0] base,
                                 input logic [3:0] size, input logic [3:0] tail);
        global_enable = en;
        sq_base_addr  = base;
        sq_size       = size;
        sq_tail       = tail;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for a command handshake, then step past the edge that takes it
    task automatic waitHandshake(input string name);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (mm2s_cmd_tvalid && mm2s_cmd_tready) got = 1'b1;
            else @(posedge clk);
        end
        if (got) begin
            @(posedge clk);
            #1;
        end else begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: handshake got none expected one within 20 cycles", name);
        end
    endtask

    // One-cycle completion pulse together with a status beat
    task automatic completeFetch(input logic [7:0] sts);
        mm2s_rd_xfer_cmplt = 1'b1;
        mm2s_sts_tvalid    = 1'b1;
        mm2s_sts_tdata     = sts;
        tick(1);
        mm2s_rd_xfer_cmplt = 1'b0;
        mm2s_sts_tvalid    = 1'b0;
        mm2s_sts_tdata     = 8'h00;
    endtask

    // Scoreboard monitor: every handshake must match the oldest expected command
    always @(negedge clk) begin
        if (rst_n && mm2s_cmd_tvalid && mm2s_cmd_tready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_cmd: got %0h expected no command", mm2s_cmd_tdata);
            end else begin
                checkOutput("cmd_tdata", mm2s_cmd_tdata, sb.pop_front());
            end
        end
    end

    // Directed test sequence
    initial begin
        rst_n              = 1'b0;
        sq_head_clr        = 1'b0;
        mm2s_cmd_tready    = 1'b0;
        mm2s_rd_xfer_cmplt = 1'b0;
        mm2s_sts_tvalid    = 1'b0;
        mm2s_sts_tdata     = 8'h00;
        applyStimulus(1'b0, 32'h0, 4'd0, 4'd0);
        tick(3);
        checkOutput("rst_head", 72'(hw_sq_head), 72'd0);
        checkOutput("rst_tvalid", 72'(mm2s_cmd_tvalid), 72'd0);
        checkOutput("rst_tdata", mm2s_cmd_tdata, 72'd0);
        checkOutput("rst_busy", 72'(busy), 72'd0);
        checkOutput("rst_err", 72'(err_flag), 72'd0);
        checkOutput("rst_count", 72'(wqe_processed), 72'd0);
        checkOutput("rst_status", 72'(status_word), 72'd0);
`ifdef STS_CHECK_EN
        checkOutput("rst_sts_tready", 72'(mm2s_sts_tready), 72'd0);
`else
        checkOutput("rst_sts_tready", 72'(mm2s_sts_tready), 72'd1);
`endif
        rst_n = 1'b1;

        $display("[TB] basic fetch");
        applyStimulus(1'b1, 32'h1000_0000, 4'd8, 4'd0);
        tick(3);
        checkOutput("empty_busy", 72'(busy), 72'd0);
        mm2s_cmd_tready = 1'b1;
        sb.push_back(mkCmd(32'h1000_0000, 4'd0));
        sq_tail = 4'd1;
        waitHandshake("basic_hs");
        checkOutput("wait_busy", 72'(busy), 72'd1);
        checkOutput("wait_tvalid", 72'(mm2s_cmd_tvalid), 72'd0);
        completeFetch(8'h80);
        checkOutput("basic_head", 72'(hw_sq_head), 72'd1);
        checkOutput("basic_count", 72'(wqe_processed), 72'd1);
        checkOutput("basic_busy", 72'(busy), 72'd0);

        $display("[TB] backpressure");
        mm2s_cmd_tready = 1'b0;
        sb.push_back(mkCmd(32'h1000_0040, 4'd1));
        sq_tail = 4'd2;
        @(posedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput("bp_tvalid", 72'(mm2s_cmd_tvalid), 72'd1);
            checkOutput("bp_tdata", mm2s_cmd_tdata, mkCmd(32'h1000_0040, 4'd1));
            @(posedge clk);
        end
        #1;
        mm2s_cmd_tready = 1'b1;
        waitHandshake("bp_hs");
        completeFetch(8'h81);
        checkOutput("bp_head", 72'(hw_sq_head), 72'd2);

        $display("[TB] wrap-around");
        sq_tail = 4'd0;
        for (int i = 2; i < 7; i++) begin
            sb.push_back(mkCmd(32'h1000_0000 + 32'(i) * 32'd64, 4'(i)));
            waitHandshake("run_hs");
            completeFetch(8'h80 | 8'(i));
        end
        checkOutput("pre_wrap_head", 72'(hw_sq_head), 72'd7);
        sb.push_back(mkCmd(32'h1000_01C0, 4'd7));
        waitHandshake("wrap_hs");
        completeFetch(8'h87);
        tick(2);
        checkOutput("wrap_head", 72'(hw_sq_head), 72'd0);
        checkOutput("wrap_busy", 72'(busy), 72'd0);

        $display("[TB] disable mid-wait");
        sb.push_back(mkCmd(32'h1000_0000, 4'd0));
        sq_tail = 4'd3;
        waitHandshake("dis_hs");
        global_enable = 1'b0;
        tick(10);
        checkOutput("dis_busy_wait", 72'(busy), 72'd1);
        checkOutput("dis_head_wait", 72'(hw_sq_head), 72'd0);
        completeFetch(8'h80);
        checkOutput("dis_head", 72'(hw_sq_head), 72'd1);
        sq_tail = 4'd4;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checkOutput("dis_no_tvalid", 72'(mm2s_cmd_tvalid), 72'd0);
        end
        tick(1);
        checkOutput("dis_count", 72'(wqe_processed), 72'd9);
        completeFetch(8'h81);
        checkOutput("idle_cmplt_head", 72'(hw_sq_head), 72'd1);
        checkOutput("idle_cmplt_count", 72'(wqe_processed), 72'd9);

        $display("[TB] invalid tail");
        sq_tail       = 4'd9;
        global_enable = 1'b1;
        tick(2);
        checkOutput("inv_err", 72'(err_flag), 72'd1);
        checkOutput("inv_status", 72'(status_word), 72'h0000_CC91);
        checkOutput("inv_tvalid", 72'(mm2s_cmd_tvalid), 72'd0);
        global_enable = 1'b0;
        tick(1);
        checkOutput("err_exit_busy", 72'(busy), 72'd0);
        checkOutput("err_sticky", 72'(err_flag), 72'd1);
        sq_tail     = 4'd0;
        sq_head_clr = 1'b1;
        tick(1);
        sq_head_clr = 1'b0;
        checkOutput("clr_err", 72'(err_flag), 72'd0);
        checkOutput("clr_head", 72'(hw_sq_head), 72'd0);
        checkOutput("clr_status", 72'(status_word), 72'd0);

`ifdef STS_CHECK_EN
        $display("[TB] status checking");
        global_enable = 1'b1;
        sb.push_back(mkCmd(32'h1000_0000, 4'd0));
        sq_tail = 4'd1;
        waitHandshake("sts_ok_hs");
        checkOutput("sts_tready_wait", 72'(mm2s_sts_tready), 72'd1);
        completeFetch(8'h80);
        checkOutput("sts_ok_head", 72'(hw_sq_head), 72'd1);
        sb.push_back(mkCmd(32'h1000_0040, 4'd1));
        sq_tail = 4'd2;
        waitHandshake("sts_bad_hs");
        completeFetch(8'hC1);
        checkOutput("sts_bad_err", 72'(err_flag), 72'd1);
        checkOutput("sts_bad_head", 72'(hw_sq_head), 72'd1);
        checkOutput("sts_bad_busy", 72'(busy), 72'd1);
`endif

        tick(3);
        checkOutput("sb_drained", 72'(sb.size()), 72'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sq_fetch_scheduler.md
Name: sq_fetch_scheduler

Overview:
Sequences the AXI DataMover MM2S read channel to fetch RDMA send-queue work-queue entries (WQEs) from host memory. The software-visible regfile supplies SQ base, size, tail and global enable. The block compares the hardware head with the tail, issues one 72-bit MM2S command per pending WQE, and waits for read completion. It then advances HW_SQ_HEAD with wrap-around. It sits between the AXI-Lite regfile and the DataMover command/status interface.

Parameters:
IDX_W, 4, width of SQ head/tail/size indices
WQE_BYTES, 64, bytes per WQE; power of two, used as BTT and address stride
ADDR_W, 32, host address width carried in the command SADDR field

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
global_enable  in  1  CTRL bit 0; enables fetching
sq_head_clr  in  1  one-cycle pulse; clears head to 0 (software SQ re-init)
sq_base_addr  in  ADDR_W  SQ_BASE_LO
sq_size  in  IDX_W  number of SQ entries; legal range 1..2^IDX_W-1
sq_tail  in  IDX_W  software producer index
hw_sq_head  out  IDX_W  hardware consumer index
mm2s_cmd_tvalid  out  1  DataMover command valid
mm2s_cmd_tready  in  1  DataMover command ready
mm2s_cmd_tdata  out  72  DataMover command word
mm2s_rd_xfer_cmplt  in  1  one-cycle read-complete pulse from DataMover
mm2s_sts_tvalid  in  1  status valid
mm2s_sts_tready  out  1  status ready
mm2s_sts_tdata  in  8  status byte
busy  out  1  high whenever state is not IDLE
err_flag  out  1  sticky error
wqe_processed  out  32  completed-fetch counter, wraps at 2^32
status_word  out  32  {16'h0, state[1:0], 2'b0, err_flag, busy, 2'b0, tail[3:0], head[3:0]} (IDX_W=4)

Behaviour:
- Reset values: all outputs 0; state IDLE; mm2s_sts_tready=1 in the non-checked build.
- States: IDLE, CMD, WAIT, ERR.
- IDLE -> CMD when global_enable=1, err_flag=0, sq_size!=0, and head!=tail.
- Empty is head==tail. The SQ is never tracked as full; software must keep one slot free.
- On entry to CMD, the command word is registered. It does not change while in CMD.
- Command fields:
  - [22:0] BTT = WQE_BYTES.
  - [23] = 1 (INCR).
  - [29:24] DSA = 0.
  - [30] EOF = 1.
  - [31] DRR = 0.
  - [63:32] SADDR = sq_base_addr + head*WQE_BYTES, computed modulo 2^32.
  - [67:64] TAG = head zero-extended or truncated to 4 bits.
  - [71:68] = 0.
- CMD: tvalid=1 and held until tready. Handshake cycle -> WAIT; tvalid drops the next cycle.
- WAIT: on mm2s_rd_xfer_cmplt, update all of the following, then go to IDLE:
  - head <= (head+1 == sq_size) ? 0 : head+1;
  - wqe_processed increments;
  - next state is IDLE.
- Back-to-back fetches: the IDLE re-evaluation adds one bubble cycle, so minimum per-WQE latency is 3 cycles plus DataMover time.
- A cmplt pulse in IDLE or CMD is ignored.
- global_enable falling during CMD or WAIT: the outstanding command completes normally (DataMover commands cannot be cancelled). No new command is issued afterward.
- sq_head_clr is honoured only in IDLE. It has priority over starting a fetch. In other states it is ignored.
- Validity check, done in IDLE when a start would occur: sq_tail >= sq_size or head >= sq_size -> err_flag=1, state ERR, no command issued.
- ERR exits to IDLE only when global_enable=0. Clearing err_flag additionally requires a sq_head_clr pulse in IDLE.
- sq_size changes are sampled only in IDLE.
- Asynchronous reset mid-operation returns everything to reset values; the DataMover must be reset alongside.

Optional Feature:
STS_CHECK_EN.
- Defined: WAIT completes only after both events have been seen, in any order:
  - the mm2s_rd_xfer_cmplt pulse;
  - a status beat (sts_tvalid with sts_tready=1).
- Status checking when defined:
  - sts_tready=1 only in WAIT.
  - Status OKAY is bit7=1 and bits[6:4]=0. A non-OKAY status sets err_flag and moves to ERR without advancing head.
  - A status TAG[3:0] that differs from the issued tag also sets err_flag.
- Undefined: sts_tready is tied 1, status is ignored, and the cmplt pulse alone completes WAIT.

Test Plan:
1. Basic fetch: base=0x1000_0000, size=8, tail=0, enable=1, then tail=1.
   - Expect tdata[63:32]=0x10000000, BTT=64, TAG=0, [23]=1, [30]=1.
   - Hold tready=1; pulse cmplt. Expect head=1, wqe_processed=1, busy=0.
2. Backpressure: tail=2 with tready low for 5 cycles.
   - Expect tvalid=1 and tdata stable (SADDR 0x10000040) for all 5 cycles.
   - Expect exactly one handshake.
3. Wrap-around: size=8, advance head to 7 with tail=0.
   - Expect SADDR 0x100001C0, TAG=7.
   - After cmplt: head=0 and busy=0, since head==tail.
4. Disable mid-WAIT: enable drops after the handshake.
   - cmplt 10 cycles later: head advances by 1.
   - No further tvalid, even with tail-head=3.
5. Invalid tail: size=8, tail=9.
   - Expect err_flag=1, state ERR, no tvalid.
   - enable=0 then sq_head_clr: expect err_flag=0, head=0.
6. STS_CHECK_EN build:
   - Status 0x80 plus cmplt: head advances.
   - Status 0xC0: err_flag=1 and head unchanged.
